// File: rtl/mips_memsys_pkg.sv
// Shared definitions for the Mips memory subsystem: state encoding, word geometry
// and the loader's byte-lane placement.
package mips_memsys_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned WORD_BYTES      = 4;
    localparam bit          LANE_BIG_ENDIAN = 1'b1;

    // Left-justify the bytes collected so far; stale high bytes of asm shift out
    // and missing low bytes fill with zero.
    function automatic logic [31:0] pack_word(input logic [23:0] asm_v,
                                              input logic [7:0]  byte_v,
                                              input logic [1:0]  bcnt_v);
        int unsigned sh;
        sh = LANE_BIG_ENDIAN ? (WORD_BYTES - 1 - 32'(bcnt_v)) * 8 : 0;
        return {asm_v, byte_v} << sh;
    endfunction

endpackage

// File: rtl/mips_memsys_if.sv
// Loader handshake and core memory bus of the Mips memory subsystem.
interface mips_memsys_if;

    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        core_reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        fault;

    modport master (
        output load_valid, load_data, load_last, pc, memwrite, aluout, writedata,
        input  load_ready, load_done, core_reset, instr, readdata, fault
    );

    modport slave (
        input  load_valid, load_data, load_last, pc, memwrite, aluout, writedata,
        output load_ready, load_done, core_reset, instr, readdata, fault
    );

endinterface

// File: rtl/mips_ram.sv
// 2**AW x 32 RAM: one synchronous write port, two asynchronous read ports.
module mips_ram #(
    parameter int unsigned AW = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [31:0]   o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [31:0]   o_rdata_b
);

    logic [31:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/mips_memsys.sv
// Unified instruction/data RAM for the single-cycle Mips core, with a byte-serial
// program loader that holds the core in reset until the image is in place.
module mips_memsys
    import mips_memsys_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    mips_memsys_if.slave  bus
);

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_bcnt, w_bcnt_nxt;
    logic [AW:0] r_wptr, w_wptr_nxt;
    logic [23:0] r_asm, w_asm_nxt;
    logic        r_fault, w_fault_nxt;

    logic          w_accept;
    logic          w_ld_we;
    logic          w_st_we;
    logic          w_st_bad;
    logic [AW:0]   w_wptr_inc;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [31:0]   w_ram_wdata;
    logic          w_unused;

    assign w_accept   = (r_state == ST_LOAD) & bus.load_valid;
    assign w_ld_we    = w_accept & (bus.load_last | (r_bcnt == 2'd3));
    assign w_wptr_inc = r_wptr + {{AW{1'b0}}, 1'b1};
    assign w_st_we    = (r_state == ST_RUN) & bus.memwrite & (bus.aluout[1:0] == 2'b00);
    assign w_st_bad   = (r_state == ST_RUN) & bus.memwrite & (bus.aluout[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_wptr_nxt  = r_wptr;
        w_asm_nxt   = r_asm;
        w_fault_nxt = r_fault | w_st_bad;
        if (w_accept) begin
            w_asm_nxt  = {r_asm[15:0], bus.load_data};
            w_bcnt_nxt = r_bcnt + 2'd1;
            if (w_ld_we) begin
                w_bcnt_nxt = 2'd0;
                w_wptr_nxt = w_wptr_inc;
                // Carry into the top pointer bit means the RAM is now full.
                if (bus.load_last || w_wptr_inc[AW]) begin
                    w_state_nxt = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_bcnt  <= 2'd0;
            r_wptr  <= '0;
            r_asm   <= 24'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_wptr  <= w_wptr_nxt;
            r_asm   <= w_asm_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign w_ram_we    = ~reset & (w_ld_we | w_st_we);
    assign w_ram_waddr = (r_state == ST_LOAD) ? r_wptr[AW-1:0] : bus.aluout[AW+1:2];
    assign w_ram_wdata = (r_state == ST_LOAD) ? pack_word(r_asm, bus.load_data, r_bcnt)
                                              : bus.writedata;

    mips_ram #(
        .AW(AW)
    ) u_ram (
        .i_clk     (clk),
        .i_we      (w_ram_we),
        .i_waddr   (w_ram_waddr),
        .i_wdata   (w_ram_wdata),
        .i_raddr_a (bus.pc[AW+1:2]),
        .o_rdata_a (bus.instr),
        .i_raddr_b (bus.aluout[AW+1:2]),
        .o_rdata_b (bus.readdata)
    );

    assign bus.load_ready = (r_state == ST_LOAD);
    assign bus.load_done  = (r_state == ST_RUN);
    assign bus.core_reset = (r_state == ST_LOAD);
    assign bus.fault      = r_fault;

    assign w_unused = ^{bus.pc[31:AW+2], bus.pc[1:0], bus.aluout[31:AW+2]};

endmodule

// File: tb/tb_mips_memsys.sv
// Scoreboard bench for mips_memsys: one instance at AW=6, one at AW=2 for capacity.
module tb_mips_memsys;

    localparam int K_INSTR_A = 0;
    localparam int K_RDATA_A = 1;
    localparam int K_STAT_A  = 2;
    localparam int K_INSTR_B = 3;
    localparam int K_STAT_B  = 4;
    localparam int K_CNT     = 5;

    // Status word: {ready, done, core_reset, fault}
    localparam logic [31:0] S_LOAD      = 32'h0000_000A;
    localparam logic [31:0] S_RUN       = 32'h0000_0004;
    localparam logic [31:0] S_RUN_FAULT = 32'h0000_0005;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic chk_en = 1'b0;
    int   acc_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    mips_memsys_if a_if();
    mips_memsys_if b_if();

    mips_memsys #(.AW(6)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if.slave)
    );

    mips_memsys #(.AW(2)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.slave)
    );

    // Monitor: pops the expected response whenever a read is presented.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] obs;
            logic [31:0] e;
            int          k;
            string       nm;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: sample with no expectation");
            end else begin
                e  = exp_q.pop_front();
                k  = kind_q.pop_front();
                nm = name_q.pop_front();
                case (k)
                    K_INSTR_A: obs = a_if.instr;
                    K_RDATA_A: obs = a_if.readdata;
                    K_STAT_A:  obs = {28'd0, a_if.load_ready, a_if.load_done,
                                      a_if.core_reset, a_if.fault};
                    K_INSTR_B: obs = b_if.instr;
                    K_STAT_B:  obs = {28'd0, b_if.load_ready, b_if.load_done,
                                      b_if.core_reset, b_if.fault};
                    default:   obs = 32'(acc_cnt);
                endcase
                if (obs === e) n_pass++;
                else $display("FAIL %s: got %h expected %h", nm, obs, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        kind_q.push_back(kind);
        name_q.push_back(name);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        a_if.load_valid = 1'b1;
        a_if.load_data  = b;
        a_if.load_last  = last;
        step();
        a_if.load_valid = 1'b0;
        a_if.load_last  = 1'b0;
    endtask

    task automatic store_a(input logic [31:0] addr, input logic [31:0] wd);
        a_if.memwrite  = 1'b1;
        a_if.aluout    = addr;
        a_if.writedata = wd;
        step();
        a_if.memwrite  = 1'b0;
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] exp, input string name);
        a_if.aluout = addr;
        chk(K_RDATA_A, exp, name);
    endtask

    task automatic if_a(input logic [31:0] addr, input logic [31:0] exp, input string name);
        a_if.pc = addr;
        chk(K_INSTR_A, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] prog [7];
        int         idx;
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00};

        a_if.load_valid = 0; a_if.load_data = 0; a_if.load_last = 0;
        a_if.pc = 0; a_if.memwrite = 0; a_if.aluout = 0; a_if.writedata = 0;
        b_if.load_valid = 0; b_if.load_data = 0; b_if.load_last = 0;
        b_if.pc = 0; b_if.memwrite = 0; b_if.aluout = 0; b_if.writedata = 0;

        rst_a = 1'b1; rst_b = 1'b1;
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;
        chk(K_STAT_A, S_LOAD, "reset_state");

        // Two-word program; last byte flagged.
        step();
        for (int i = 0; i < 7; i++) send_a(prog[i], 1'b0);
        a_if.load_valid = 1'b1; a_if.load_data = 8'h07; a_if.load_last = 1'b1;
        chk(K_STAT_A, S_LOAD, "still_load_on_last_byte");
        step();
        a_if.load_valid = 1'b0; a_if.load_last = 1'b0;
        chk(K_STAT_A, S_RUN, "run_after_last_byte");
        if_a(32'h4, 32'h2009_0007, "instr_pc4");
        if_a(32'h0, 32'h2008_0005, "instr_pc0");
        rd_a(32'h5, 32'h2009_0007, "readdata_low_bits_ignored");

        // Aligned store, then misaligned store.
        step();
        store_a(32'h10, 32'hDEAD_BEEF);
        rd_a(32'h10, 32'hDEAD_BEEF, "store_visible");
        rd_a(32'h110, 32'hDEAD_BEEF, "readdata_wraps");
        chk(K_STAT_A, S_RUN, "no_fault_aligned");
        step();
        store_a(32'h12, 32'h1234_5678);
        rd_a(32'h10, 32'hDEAD_BEEF, "misaligned_suppressed");
        chk(K_STAT_A, S_RUN_FAULT, "fault_set");
        step(); step();
        chk(K_STAT_A, S_RUN_FAULT, "fault_sticky");

        // Reset mid-run, then 6-byte partial load.
        step();
        reset_a();
        chk(K_STAT_A, S_LOAD, "reset_mid_run");
        step();
        send_a(8'h11, 0); send_a(8'h22, 0); send_a(8'h33, 0); send_a(8'h44, 0);
        send_a(8'h55, 0); send_a(8'h66, 1);
        chk(K_STAT_A, S_RUN, "run_after_6_bytes");
        rd_a(32'h0, 32'h1122_3344, "six_byte_word0");
        rd_a(32'h4, 32'h5566_0000, "six_byte_word1_padded");
        rd_a(32'h10, 32'hDEAD_BEEF, "ram_kept_across_reset");

        // Stores ignored while loading.
        step();
        reset_a();
        store_a(32'h0, 32'hFFFF_FFFF);
        store_a(32'h2, 32'hFFFF_FFFF);
        rd_a(32'h0, 32'h1122_3344, "store_ignored_in_load");
        chk(K_STAT_A, S_LOAD, "no_fault_in_load");

        // Reset after two bytes: loading restarts at word 0, byte 0.
        step();
        send_a(8'hAA, 0); send_a(8'hBB, 0);
        reset_a();
        chk(K_STAT_A, S_LOAD, "reset_mid_load");
        step();
        send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h03, 0); send_a(8'h04, 0);
        send_a(8'h12, 0); send_a(8'hAB, 1);
        rd_a(32'h0, 32'h0102_0304, "reload_word0");
        rd_a(32'h4, 32'h12AB_0000, "reload_word1_padded");
        chk(K_STAT_A, S_RUN, "run_after_reload");

        // AW=2: stream 20 bytes into a 16-byte RAM.
        step();
        idx = 0;
        b_if.load_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            b_if.load_data = 8'h10 + 8'(idx);
            @(negedge clk);
            if (b_if.load_ready) begin
                acc_cnt++;
                idx++;
            end
            step();
        end
        b_if.load_valid = 1'b0;
        chk(K_CNT, 32'd16, "bytes_accepted");
        chk(K_STAT_B, S_RUN, "full_ram_run");
        b_if.pc = 32'h10;
        chk(K_INSTR_B, 32'h1011_1213, "pc_alias_word0");
        b_if.pc = 32'hC;
        chk(K_INSTR_B, 32'h1C1D_1E1F, "last_word");
        b_if.pc = 32'h8;
        chk(K_INSTR_B, 32'h1819_1A1B, "word2");

        step();
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_total++;
            $display("FAIL scoreboard_leftover: expectation never sampled");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
